// File: rtl/dp_pipeline_skid_register.sv
// Valid/ready pipeline register with an optional two-entry skid buffer.
// Main entry M drives the outputs; skid entry S catches the one extra
// transfer that arrives while downstream stalls, so ReadyOut is registered.
module dp_pipeline_skid_register #(
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        PAYLOAD_W = 64,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013),
  parameter bit                 SKID_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 FlushIn,
  input  logic                 ValidIn,
  output logic                 ReadyOut,
  input  logic [INSTR_W-1:0]   InstrIn,
  input  logic [PAYLOAD_W-1:0] PayloadIn,
  output logic                 ValidOut,
  input  logic                 ReadyIn,
  output logic [INSTR_W-1:0]   InstrOut,
  output logic [PAYLOAD_W-1:0] PayloadOut
);

  localparam int unsigned ENTRY_W = INSTR_W + PAYLOAD_W;
  localparam logic [ENTRY_W-1:0] NOP_ENTRY = {NOP_INSTR, PAYLOAD_W'(0)};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e               state_q, state_d;
  logic [ENTRY_W-1:0] m_q, m_d;
  logic [ENTRY_W-1:0] s_q, s_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic [ENTRY_W-1:0] entry_in;
  logic               up_xfer;
  logic               dn_xfer;

  // Without the skid entry, ready must see downstream in the same cycle.
  assign ReadyOut = SKID_EN ? ready_q : (ReadyIn || !valid_q);
  assign ValidOut = valid_q;
  // M is parked at NOP_ENTRY whenever invalid, so no output masking needed.
  assign {InstrOut, PayloadOut} = m_q;

  assign entry_in = {InstrIn, PayloadIn};
  assign up_xfer  = ValidIn && ReadyOut;
  assign dn_xfer  = valid_q && ReadyIn;

  // State and storage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      m_q     <= NOP_ENTRY;
      s_q     <= NOP_ENTRY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  // Occupancy next-state and data movement; flush overrides everything.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    valid_d = 1'b0;
    ready_d = 1'b1;
    if (FlushIn) begin
      state_d = EMPTY;
      m_d     = NOP_ENTRY;
      s_d     = NOP_ENTRY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (up_xfer) begin
            m_d     = entry_in;
            state_d = ONE;
          end
        end
        ONE: begin
          if (dn_xfer) begin
            if (up_xfer) begin
              m_d = entry_in;
            end else begin
              m_d     = NOP_ENTRY;
              state_d = EMPTY;
            end
          end else if (up_xfer && SKID_EN) begin
            s_d     = entry_in;
            state_d = FULL;
          end
        end
        FULL: begin
          if (dn_xfer) begin
            m_d     = s_q;
            s_d     = NOP_ENTRY;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          m_d     = NOP_ENTRY;
          s_d     = NOP_ENTRY;
        end
      endcase
    end
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
  end

endmodule

// File: tb/tb_dp_pipeline_skid_register.sv
// Directed and scoreboarded checks of the skid register, with and without skid.
module tb_dp_pipeline_skid_register;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I0  = 32'h10000093;
  localparam logic [31:0] I1  = 32'h10000094;
  localparam logic [31:0] I2  = 32'h10000095;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_flush, a_vin, a_rin, a_rdy, a_vout;
  logic [31:0] a_instr, a_iout;
  logic [63:0] a_payload, a_pout;
  logic        b_flush, b_vin, b_rin, b_rdy, b_vout;
  logic [31:0] b_instr, b_iout;
  logic [63:0] b_payload, b_pout;

  int passed = 0;
  int total  = 0;
  int a_pushed = 0;
  int b_pushed = 0;
  logic [95:0] qa[$];
  logic [95:0] qb[$];

  always #5 clk = ~clk;

  dp_pipeline_skid_register #(.SKID_EN(1'b1)) u_skid (
    .clk(clk), .reset(reset), .FlushIn(a_flush), .ValidIn(a_vin),
    .ReadyOut(a_rdy), .InstrIn(a_instr), .PayloadIn(a_payload),
    .ValidOut(a_vout), .ReadyIn(a_rin), .InstrOut(a_iout), .PayloadOut(a_pout)
  );

  dp_pipeline_skid_register #(.SKID_EN(1'b0)) u_reg (
    .clk(clk), .reset(reset), .FlushIn(b_flush), .ValidIn(b_vin),
    .ReadyOut(b_rdy), .InstrIn(b_instr), .PayloadIn(b_payload),
    .ValidOut(b_vout), .ReadyIn(b_rin), .InstrOut(b_iout), .PayloadOut(b_pout)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One scoreboarded cycle for both instances; inputs already driven.
  task automatic sb_cycle();
    logic [95:0] e;
    logic        rdy_a, rdy_b;
    #1;
    rdy_a = (qa.size() < 2);
    check("a_valid", a_vout, qa.size() != 0);
    check("a_ready", a_rdy, rdy_a);
    if (qa.size() == 0) begin
      check("a_nop_instr", a_iout, NOP);
      check("a_nop_payload", a_pout, 0);
    end
    if (a_flush) qa.delete();
    else begin
      if (a_rin && qa.size() != 0) begin
        e = qa.pop_front();
        check("a_order", {a_iout, a_pout}, e);
      end
      if (a_vin && rdy_a) begin
        qa.push_back({a_instr, a_payload});
        a_pushed++;
      end
    end
    rdy_b = b_rin || (qb.size() == 0);
    check("b_valid", b_vout, qb.size() != 0);
    check("b_ready", b_rdy, rdy_b);
    if (qb.size() == 0) begin
      check("b_nop_instr", b_iout, NOP);
      check("b_nop_payload", b_pout, 0);
    end
    if (b_flush) qb.delete();
    else begin
      if (b_rin && qb.size() != 0) begin
        e = qb.pop_front();
        check("b_order", {b_iout, b_pout}, e);
      end
      if (b_vin && rdy_b) begin
        qb.push_back({b_instr, b_payload});
        b_pushed++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_flush = 0; a_vin = 1; a_rin = 0; a_instr = 32'h00500093; a_payload = 64'h55;
    b_flush = 0; b_vin = 1; b_rin = 0; b_instr = 32'h00500093; b_payload = 64'h55;
    step();
    check("rst_a_valid", a_vout, 0);
    check("rst_a_instr", a_iout, NOP);
    check("rst_a_payload", a_pout, 0);
    check("rst_a_ready", a_rdy, 1);
    check("rst_b_valid", b_vout, 0);
    check("rst_b_ready", b_rdy, 1);
    a_vin = 0; b_vin = 0;
    step();
    reset = 1'b0;

    // Streaming with downstream always ready.
    a_rin = 1; b_rin = 1;
    for (int k = 0; k < 4; k++) begin
      a_vin = 1; a_instr = I0 + 32'(k); a_payload = 64'(k * 4);
      b_vin = 1; b_instr = I0 + 32'(k); b_payload = 64'(k * 4);
      step();
      check("str_a_valid", a_vout, 1);
      check("str_a_instr", a_iout, I0 + 32'(k));
      check("str_a_payload", a_pout, 64'(k * 4));
      check("str_b_instr", b_iout, I0 + 32'(k));
      check("str_b_ready", b_rdy, 1);
    end
    a_vin = 0; b_vin = 0;
    step();
    check("str_a_drain", a_vout, 0);
    check("str_a_drain_instr", a_iout, NOP);
    check("str_b_drain", b_vout, 0);

    // Stall fills the skid entry, then drains in order.
    a_rin = 0; a_vin = 1; a_instr = I0; a_payload = 64'h0;
    step();
    check("stl_m_i0", a_iout, I0);
    check("stl_rdy_one", a_rdy, 1);
    a_instr = I1; a_payload = 64'h4;
    step();
    check("stl_rdy_full", a_rdy, 0);
    check("stl_hold_i0", a_iout, I0);
    a_instr = I2; a_payload = 64'h8;
    step();
    check("stl_hold2", a_iout, I0);
    check("stl_hold2_pay", a_pout, 0);
    step();
    check("stl_hold3", a_iout, I0);
    check("stl_rdy_full3", a_rdy, 0);
    a_vin = 0; a_rin = 1;
    step();
    check("stl_out_i1", a_iout, I1);
    check("stl_out_i1_pay", a_pout, 64'h4);
    check("stl_rdy_back", a_rdy, 1);
    step();
    check("stl_empty", a_vout, 0);

    // Flush in FULL with a simultaneous upstream offer.
    a_rin = 0; a_vin = 1; a_instr = I0; a_payload = 64'h0;
    step();
    a_instr = I1; a_payload = 64'h4;
    step();
    check("fl_full", a_rdy, 0);
    a_flush = 1; a_instr = I2; a_payload = 64'h8;
    step();
    check("fl_valid", a_vout, 0);
    check("fl_instr", a_iout, NOP);
    check("fl_payload", a_pout, 0);
    check("fl_ready", a_rdy, 1);
    a_flush = 0; a_vin = 0; a_rin = 1;
    step();
    check("fl_no_ghost", a_vout, 0);

    // Asynchronous reset while FULL.
    a_rin = 0; a_vin = 1; a_instr = I0;
    step();
    a_instr = I1;
    step();
    a_vin = 0;
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", a_vout, 0);
    check("ar_instr", a_iout, NOP);
    check("ar_ready", a_rdy, 1);
    step();
    reset = 1'b0;
    a_rin = 1;
    step();
    check("ar_stays_empty", a_vout, 0);

    // Non-skid instance with ReadyIn toggling under a continuous stream.
    qa.delete(); qb.delete();
    a_vin = 0; a_rin = 1;
    for (int k = 0; k < 16; k++) begin
      b_vin = 1; b_rin = k[0];
      b_instr = 32'h20000093 + 32'(b_pushed); b_payload = 64'(b_pushed);
      sb_cycle();
    end

    // Random traffic on both instances.
    for (int k = 0; k < 3000; k++) begin
      a_vin = ($urandom_range(0, 3) != 0); a_rin = ($urandom_range(0, 3) != 0);
      a_flush = ($urandom_range(0, 49) == 0);
      a_instr = 32'h30000000 + 32'(a_pushed);
      a_payload = {32'(a_pushed), 32'(a_pushed * 7 + 1)};
      b_vin = ($urandom_range(0, 3) != 0); b_rin = ($urandom_range(0, 3) != 0);
      b_flush = ($urandom_range(0, 49) == 0);
      b_instr = 32'h40000000 + 32'(b_pushed);
      b_payload = {32'(b_pushed), 32'(b_pushed * 5 + 3)};
      sb_cycle();
    end
    a_vin = 0; a_rin = 1; a_flush = 0;
    b_vin = 0; b_rin = 1; b_flush = 0;
    for (int k = 0; k < 4; k++) sb_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
